// File: rtl/hdmi_link_ctrl.sv
// ============================================================================
// Module   : hdmi_link_ctrl
// Brief    : Bring-up/recovery sequencer for the TMDS serializer path
//            (pixel clock domain).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hdmi_link_ctrl #(
  parameter int NUM_CHANNELS  = 3,
  parameter int RESET_CYCLES  = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HPD_DEBOUNCE  = 65536
) (
  input  logic                      clk_pixel,
  input  logic                      reset_n,
  input  logic                      pll_locked,
  input  logic                      hpd,
  input  logic                      retrain,
  input  logic [NUM_CHANNELS*10-1:0] tmds_in,
  output logic [NUM_CHANNELS*10-1:0] tmds_out,
  output logic                      serializer_reset,
  output logic                      video_enable,
  output logic [1:0]                state_dbg,
  output logic [7:0]                lock_loss_count
);

  localparam int c_max_a = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int c_max   = (c_max_a > HPD_DEBOUNCE) ? c_max_a : HPD_DEBOUNCE;
  localparam int CNT_W   = $clog2(c_max);

  localparam logic [CNT_W-1:0] c_rst_last = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_set_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(HPD_DEBOUNCE - 1);
  localparam logic [9:0]       c_ctrl     = 10'b1101010100;

  localparam logic [1:0] c_st_idle   = 2'b00;
  localparam logic [1:0] c_st_ser    = 2'b01;
  localparam logic [1:0] c_st_settle = 2'b10;
  localparam logic [1:0] c_st_active = 2'b11;

  logic                      r_lock_meta, r_lock_s, r_hpd_meta, r_hpd_s, r_hpd_deb;
  logic [CNT_W-1:0]          r_deb_cnt, r_cnt;
  logic [1:0]                r_state, w_state_nxt;
  logic                      w_link_ok, w_cnt_clr, w_lock_loss;
  logic                      w_ser_reset_nxt, w_video_nxt;
  logic [NUM_CHANNELS*10-1:0] w_tmds_nxt;
  logic [NUM_CHANNELS*10-1:0] r_tmds;
  logic                      r_ser_reset, r_video;
  logic [7:0]                r_lock_loss;

  // Synchronisers and HPD debounce; hpd_deb only follows hpd_s after it has
  // disagreed for HPD_DEBOUNCE consecutive cycles.
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_hpd_meta  <= 1'b0;
      r_hpd_s     <= 1'b0;
      r_hpd_deb   <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
      r_hpd_meta  <= hpd;
      r_hpd_s     <= r_hpd_meta;
      if (r_hpd_s == r_hpd_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_deb_last) begin
        r_hpd_deb <= r_hpd_s;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_link_ok = r_lock_s && r_hpd_deb;

  // State register and shared cycle counter
  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state == c_st_ser || r_state == c_st_settle)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next state: link loss beats retrain beats normal progression
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_lock_loss = 1'b0;
    if (r_state != c_st_idle && !w_link_ok) begin
      w_state_nxt = c_st_idle;
      w_cnt_clr   = 1'b1;
      w_lock_loss = !r_lock_s;
    end else if (r_state != c_st_idle && retrain) begin
      w_state_nxt = c_st_ser;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        c_st_idle: if (w_link_ok) begin
          w_state_nxt = c_st_ser;
          w_cnt_clr   = 1'b1;
        end
        c_st_ser: if (r_cnt == c_rst_last) begin
          w_state_nxt = c_st_settle;
          w_cnt_clr   = 1'b1;
        end
        c_st_settle: if (r_cnt == c_set_last) begin
          w_state_nxt = c_st_active;
          w_cnt_clr   = 1'b1;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Outputs decoded from the state being entered so they line up with state_dbg
  always_comb begin
    w_ser_reset_nxt = (w_state_nxt == c_st_idle) || (w_state_nxt == c_st_ser);
    w_video_nxt     = (w_state_nxt == c_st_active);
  end

  generate
    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      assign w_tmds_nxt[i*10 +: 10] = w_video_nxt ? tmds_in[i*10 +: 10] : c_ctrl;
    end
  endgenerate

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      r_tmds      <= {NUM_CHANNELS{c_ctrl}};
      r_ser_reset <= 1'b1;
      r_video     <= 1'b0;
      r_lock_loss <= 8'd0;
    end else begin
      r_tmds      <= w_tmds_nxt;
      r_ser_reset <= w_ser_reset_nxt;
      r_video     <= w_video_nxt;
      if (w_lock_loss && r_lock_loss != 8'hFF)
        r_lock_loss <= r_lock_loss + 8'd1;
    end
  end

  assign tmds_out         = r_tmds;
  assign serializer_reset = r_ser_reset;
  assign video_enable     = r_video;
  assign state_dbg        = r_state;
  assign lock_loss_count  = r_lock_loss;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_link_ctrl.sv
// ============================================================================
// Module   : tb_hdmi_link_ctrl
// Brief    : Directed self-checking bench for hdmi_link_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hdmi_link_ctrl;

  localparam int NUM_CHANNELS = 3;
  localparam logic [29:0] c_ctrl3 = {3{10'h354}};

  logic        clk_pixel = 1'b0;
  logic        reset_n, pll_locked, hpd, retrain;
  logic [29:0] tmds_in, tmds_out;
  logic        serializer_reset, video_enable;
  logic [1:0]  state_dbg;
  logic [7:0]  lock_loss_count;

  int n_checks = 0;
  int n_errors = 0;

  hdmi_link_ctrl #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .RESET_CYCLES (16),
    .SETTLE_CYCLES(32),
    .HPD_DEBOUNCE (4)
  ) dut (
    .clk_pixel       (clk_pixel),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .hpd             (hpd),
    .retrain         (retrain),
    .tmds_in         (tmds_in),
    .tmds_out        (tmds_out),
    .serializer_reset(serializer_reset),
    .video_enable    (video_enable),
    .state_dbg       (state_dbg),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pixel);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    hpd        = 1'b1;
    retrain    = 1'b0;
    tmds_in    = {3{10'h2AA}};
    tick(3);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_ser", 32'(serializer_reset), 32'd1);
    chk("rst_video", 32'(video_enable), 32'd0);
    chk("rst_tmds", 32'(tmds_out), 32'(c_ctrl3));
    chk("rst_llc", 32'(lock_loss_count), 32'd0);

    // Bring-up: 2 sync + 4 debounce cycles, SER_RESET on 7th edge
    reset_n = 1'b1;
    tick(6);
    chk("up_idle", 32'(state_dbg), 32'd0);
    tick(1);
    chk("up_ser", 32'(state_dbg), 32'd1);
    chk("up_ser_rst", 32'(serializer_reset), 32'd1);
    tick(15);
    chk("ser_last", 32'(state_dbg), 32'd1);
    chk("ser_last_rst", 32'(serializer_reset), 32'd1);
    tick(1);
    chk("settle", 32'(state_dbg), 32'd2);
    chk("settle_rst", 32'(serializer_reset), 32'd0);
    chk("settle_tmds", 32'(tmds_out), 32'(c_ctrl3));
    tick(31);
    chk("settle_last", 32'(state_dbg), 32'd2);
    chk("settle_last_tmds", 32'(tmds_out), 32'(c_ctrl3));
    chk("settle_last_vid", 32'(video_enable), 32'd0);
    tick(1);
    chk("active", 32'(state_dbg), 32'd3);
    chk("active_vid", 32'(video_enable), 32'd1);
    chk("active_tmds", 32'(tmds_out), 32'({3{10'h2AA}}));
    tmds_in = {10'h111, 10'h222, 10'h0F0};
    chk("pass_hold", 32'(tmds_out), 32'({3{10'h2AA}}));
    tick(1);
    chk("pass_lat", 32'(tmds_out), 32'({10'h111, 10'h222, 10'h0F0}));

    // Lock loss in ACTIVE
    pll_locked = 1'b0;
    tick(2);
    chk("ll_still_act", 32'(state_dbg), 32'd3);
    tick(1);
    chk("ll_idle", 32'(state_dbg), 32'd0);
    chk("ll_vid", 32'(video_enable), 32'd0);
    chk("ll_ser", 32'(serializer_reset), 32'd1);
    chk("ll_tmds", 32'(tmds_out), 32'(c_ctrl3));
    chk("ll_cnt", 32'(lock_loss_count), 32'd1);
    pll_locked = 1'b1;
    tick(2);
    chk("relock_idle", 32'(state_dbg), 32'd0);
    tick(1);
    chk("relock_ser", 32'(state_dbg), 32'd1);
    tick(48);
    chk("relock_act", 32'(state_dbg), 32'd3);

    // Retrain in ACTIVE
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rt_ser", 32'(state_dbg), 32'd1);
    chk("rt_ser_rst", 32'(serializer_reset), 32'd1);
    chk("rt_tmds", 32'(tmds_out), 32'(c_ctrl3));
    tick(15);
    chk("rt_ser_last", 32'(state_dbg), 32'd1);
    tick(32);
    chk("rt_settle_last", 32'(state_dbg), 32'd2);
    tick(1);
    chk("rt_act", 32'(state_dbg), 32'd3);

    // Short HPD glitch is filtered
    hpd = 1'b0;
    tick(2);
    hpd = 1'b1;
    tick(6);
    chk("hpd_glitch", 32'(state_dbg), 32'd3);

    // Long HPD drop: IDLE without counting a lock loss
    hpd = 1'b0;
    tick(5);
    hpd = 1'b1;
    tick(1);
    chk("hpd_long_act", 32'(state_dbg), 32'd3);
    tick(1);
    chk("hpd_long_idle", 32'(state_dbg), 32'd0);
    chk("hpd_long_llc", 32'(lock_loss_count), 32'd1);

    // Retrain in IDLE is ignored; HPD re-debounce brings link back
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rt_idle", 32'(state_dbg), 32'd0);
    tick(3);
    chk("hpd_back_idle", 32'(state_dbg), 32'd0);
    tick(1);
    chk("hpd_back_ser", 32'(state_dbg), 32'd1);
    tick(26);
    chk("mid_settle", 32'(state_dbg), 32'd2);

    // Retrain coincident with lock loss: lock loss wins
    pll_locked = 1'b0;
    tick(2);
    retrain = 1'b1;
    tick(1);
    retrain = 1'b0;
    chk("rt_ll_idle", 32'(state_dbg), 32'd0);
    chk("rt_ll_cnt", 32'(lock_loss_count), 32'd2);

    // Saturation of lock-loss counter
    for (int i = 0; i < 252; i++) begin
      pll_locked = 1'b1;
      tick(3);
      pll_locked = 1'b0;
      tick(3);
    end
    chk("sat_254", 32'(lock_loss_count), 32'd254);
    for (int i = 0; i < 48; i++) begin
      pll_locked = 1'b1;
      tick(3);
      pll_locked = 1'b0;
      tick(3);
    end
    chk("sat_255", 32'(lock_loss_count), 32'd255);
    chk("sat_state", 32'(state_dbg), 32'd0);

    // Reset asserted mid-SETTLE
    pll_locked = 1'b1;
    tick(3);
    chk("pre_rst_ser", 32'(state_dbg), 32'd1);
    tick(21);
    chk("pre_rst_settle", 32'(state_dbg), 32'd2);
    reset_n = 1'b0;
    tick(1);
    chk("mr_state", 32'(state_dbg), 32'd0);
    chk("mr_ser", 32'(serializer_reset), 32'd1);
    chk("mr_tmds", 32'(tmds_out), 32'(c_ctrl3));
    chk("mr_vid", 32'(video_enable), 32'd0);
    chk("mr_llc", 32'(lock_loss_count), 32'd0);
    reset_n = 1'b1;
    tick(6);
    chk("mr_up_idle", 32'(state_dbg), 32'd0);
    tick(1);
    chk("mr_up_ser", 32'(state_dbg), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hdmi_link_ctrl.md
Name: hdmi_link_ctrl

Overview:
Sequences bring-up and recovery of the HDMI TMDS serializer path in the clk_pixel domain. It waits for the external PLL to lock and for the sink to be present (HPD). It then holds the serializer data reset and drives stable control-period symbols until the link has settled. Only after that does it pass encoder TMDS words through to the serializer and tell the upstream video path to run. Sits between the TMDS encoders and the serializer; its serializer_reset output drives the serializer's data reset.

Parameters:
NUM_CHANNELS, 3, number of TMDS data channels passed through
RESET_CYCLES, 16, clk_pixel cycles serializer_reset is held in SER_RESET (>=1)
SETTLE_CYCLES, 1024, clk_pixel cycles of control symbols before ACTIVE (>=1)
HPD_DEBOUNCE, 65536, cycles the synchronised HPD must stay constant before the debounced value changes (>=2)

Ports:
clk_pixel  in  1  pixel clock; sole clock
reset_n  in  1  synchronous, active-low reset
pll_locked  in  1  PLL lock; asynchronous, 2-flop synchronised internally
hpd  in  1  hot-plug detect; asynchronous, 2-flop synchronised, then debounced
retrain  in  1  single-cycle pulse; forces re-sequencing from SER_RESET
tmds_in  in  [9:0] x NUM_CHANNELS  encoder output words
tmds_out  out  [9:0] x NUM_CHANNELS  words to serializer
serializer_reset  out  1  serializer data reset, active-high
video_enable  out  1  high only in ACTIVE
state_dbg  out  2  00 IDLE, 01 SER_RESET, 10 SETTLE, 11 ACTIVE
lock_loss_count  out  8  saturating count of PLL lock losses outside IDLE

Behaviour:
- All outputs are registered.
- Reset (reset_n=0 at a clk_pixel edge):
  - state=IDLE; serializer_reset=1; video_enable=0.
  - tmds_out = CTRL on all channels, where CTRL = 10'b1101010100 (control period, c1c0=00).
  - All counters=0; debounced HPD=0; lock_loss_count=0.
- Synchroniser reset: pll_locked and hpd synchronisers reset to 0. lock_s and hpd_s are the synchronised values; each adds 2 cycles of latency.
- HPD debounce: a counter runs while hpd_s differs from hpd_deb and clears when they match. hpd_deb takes hpd_s when the counter reaches HPD_DEBOUNCE-1.
- link_ok = lock_s && hpd_deb.
- Next state is evaluated every cycle, in this priority:
  1. !link_ok in any state other than IDLE -> IDLE. If lock_s=0 caused it, increment lock_loss_count, saturating at 255.
  2. retrain=1 in SER_RESET, SETTLE or ACTIVE -> SER_RESET with the counter cleared. retrain is ignored in IDLE.
  3. Normal progression:
     - IDLE -> SER_RESET when link_ok.
     - SER_RESET: count 0..RESET_CYCLES-1, then -> SETTLE.
     - SETTLE: count 0..SETTLE_CYCLES-1, then -> ACTIVE.
     - ACTIVE: hold.
- A single shared cycle counter clears on every state entry.
- Outputs, registered from the state being entered so they align with state_dbg:
  - serializer_reset = 1 in IDLE and SER_RESET, else 0.
  - video_enable = 1 in ACTIVE only.
  - tmds_out = CTRL on every channel in IDLE, SER_RESET and SETTLE.
  - In ACTIVE, tmds_out[i] = tmds_in[i] registered, i.e. 1-cycle latency.
  - The switch into and out of pass-through happens on the same edge as the state_dbg change; no partial or mixed word is ever emitted.
- Timing contract: serializer_reset stays high for exactly RESET_CYCLES cycles after leaving IDLE. Entry to ACTIVE occurs RESET_CYCLES+SETTLE_CYCLES cycles after leaving IDLE, absent interruptions.
- Simultaneous lock loss and retrain: lock loss wins.
- Lock and HPD both lost in the same cycle: lock_loss_count still increments.
- Lock glitch shorter than 1 cycle: may be missed by the synchroniser. This is acceptable.
- Counters use clog2 of the maximum of the parameters and never wrap.

Test Plan:
- Reset, then pll_locked=1 and hpd=1 held (HPD_DEBOUNCE=4, RESET_CYCLES=16, SETTLE_CYCLES=32) -> IDLE until link_ok; serializer_reset high for 16 cycles after SER_RESET entry; CTRL (0x354) on all channels through SETTLE; ACTIVE after 48 further cycles; tmds_in=0x2AA appears on tmds_out 1 cycle later; video_enable=1.
- In ACTIVE, drop pll_locked -> IDLE 3 cycles later (2 sync + 1); video_enable=0; serializer_reset=1; tmds_out=CTRL; lock_loss_count=1. Restore lock -> full resequence.
- retrain pulse in ACTIVE -> SER_RESET next cycle, counter restarts, ACTIVE again after 48 cycles. retrain pulse in IDLE -> no change.
- hpd low for 2 cycles (< HPD_DEBOUNCE) in ACTIVE -> stays ACTIVE. hpd low for 5 cycles -> IDLE; lock_loss_count unchanged.
- retrain and pll_locked drop arriving together -> IDLE, count increments. Then 300 lock-loss events -> lock_loss_count saturates at 255.
- reset_n asserted mid-SETTLE -> next edge: IDLE, serializer_reset=1, tmds_out=CTRL, counters 0, lock_loss_count 0.
